pattern_player: RTL and testbench
=================================

# pattern_player

Plays back the first N 3-bit patterns produced by the pattern generator as a one-hot LED sequence. It sits directly downstream of the generator and upstream of the LED driver and game manager. The game manager loads it with the 16-entry pattern bus and a level-dependent length, pulses `start`, and waits for `done` before enabling player input.

## Interface
Parameters:
- `HOLD_TICKS`, default 4: ticks each pattern stays lit (1..255).
- `GAP_TICKS`, default 1: blank ticks between consecutive patterns (1..255); only used with the gap feature enabled.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `tick` in 1: one-cycle pacing strobe, synchronous to `clk`.
- `start` in 1: one-cycle request to begin playback.
- `abort` in 1: synchronous cancel.
- `patterns` in 48: pattern k (1..16) at bits [3k-1:3k-3].
- `length` in 5: number of patterns to play.
- `led` out 8: one-hot display, `1 << pattern`; 0 when blank.
- `led_valid` out 1: high while a pattern is displayed.
- `index` out 4: zero-based index of the pattern being shown.
- `busy` out 1: playback in progress.
- `done` out 1: one-cycle completion pulse.

## Operation
- States are IDLE, SHOW, GAP and FIN. All outputs are registered.
- **IDLE**
  - On `start=1`, latch `patterns` into an internal 48-bit register and latch the clamped length: 0 becomes 1, values above 16 become 16.
  - Then clear `index` and the tick counter and go to SHOW.
  - `start` is ignored in every other state.
  - Input changes after latching have no effect on the current playback.
- **SHOW**
  - `led = 1 << pat[index]`, `led_valid=1`, `busy=1`.
  - The counter increments on each `tick`.
  - On the tick that makes the count equal `HOLD_TICKS`, clear the counter and branch:
    - If `index == len-1`, go to FIN.
    - Otherwise, with the gap feature enabled, go to GAP.
    - Otherwise, increment `index` and stay in SHOW.
- **GAP**
  - `led=0`, `led_valid=0`, `busy=1`.
  - After `GAP_TICKS` ticks, increment `index` and go to SHOW.
- **FIN**
  - `done=1`, `busy=0`, `led=0` for exactly one cycle, then return to IDLE.
- **abort**
  - In SHOW or GAP, the next state is IDLE.
  - `led`, `led_valid` and `busy` clear, and `done` is not pulsed.
  - `abort` has priority over a coinciding final tick.
  - In IDLE and FIN, `abort` is ignored.
- **Counter and index widths:** the tick counter is 8 bits and never wraps, because it clears on the terminal count. `index` never exceeds 15.

## Timing
- Reset values: `led=0`, `led_valid=0`, `index=0`, `busy=0`, `done=0`, state IDLE, latched registers 0.
  - Reset asserted mid-playback forces these values immediately.
  - No `done` is produced.
- A `start` sampled at edge T shows pattern 0 on the outputs after edge T.
- A `tick` coinciding with the `start` cycle is not counted. Counting begins with ticks sampled at edge T+1 or later.
- Each transition happens on the edge that samples the terminal `tick`, so outputs change in the following cycle.
- `done` rises one cycle after the final SHOW terminal tick and lasts 1 cycle.
- A new `start` is accepted at the earliest in the cycle after `done`.
- Total playback with gaps = `len*HOLD_TICKS + (len-1)*GAP_TICKS` ticks.

## Configuration
- `PATTERN_PLAYER_GAP_EN` defined:
  - The GAP state is compiled in, so every pair of consecutive patterns is separated by `GAP_TICKS` blank ticks.
  - This lets the player distinguish repeated values.
- `PATTERN_PLAYER_GAP_EN` undefined:
  - The GAP state and `GAP_TICKS` logic are absent, and patterns play back-to-back.
  - `led_valid` stays high from the first pattern until FIN.

## Test plan
1. **Basic sequence.** `HOLD_TICKS=2`, `GAP_TICKS=1`, gap enabled, `tick` every 4 cycles, patterns 1..3 = 5,0,7, `length=3`, pulse `start`.
   - `led` sequence is 0x20, 0x00, 0x01, 0x00, 0x80, 0x00.
   - Each lit value lasts 2 ticks and each blank lasts 1 tick.
   - `index` steps 0,1,2.
   - One `done` pulse follows 8 ticks after start.
2. **Gap disabled, repeated values.** Gap disabled, `length=2`, patterns 3,3.
   - `led=0x08` continuously for 4 ticks with `led_valid` high throughout, then `done`.
3. **Length clamping.**
   - `length=0` plays only pattern 1, then `done`.
   - `length=20` plays exactly 16 patterns, with final `index=15`.
4. **Abort and ignored start.**
   - `abort` asserted in the same cycle as the final terminal tick: state returns to IDLE, `done` never pulses, `busy=0` next cycle.
   - `start` during SHOW is ignored, and `index` is unchanged.
5. **Reset mid-playback.** `rst=0` asynchronously during SHOW with `index=2`.
   - All outputs go to 0 without waiting for a clock edge.
   - After release, a fresh `start` plays from `index` 0.
6. **Input isolation and tick counting.** Change `patterns` and `length` mid-playback, and issue a `tick` in the same cycle as `start`.
   - The displayed sequence matches the values latched at `start`.
   - The first pattern is held for a full `HOLD_TICKS` ticks after start.

Source files
------------

// File: rtl/pattern_player_if.sv
// Interface bundle between the game manager and pattern_player.
// The master side (game manager) drives the control strobes and the pattern
// bus. The slave side (the player) drives the registered display and status
// outputs.
interface pattern_player_if;
    logic        tick;
    logic        start;
    logic        abort;
    logic [47:0] patterns;
    logic [4:0]  length;
    logic [7:0]  led;
    logic        led_valid;
    logic [3:0]  index;
    logic        busy;
    logic        done;

    modport master (
        output tick, start, abort, patterns, length,
        input  led, led_valid, index, busy, done
    );

    modport slave (
        input  tick, start, abort, patterns, length,
        output led, led_valid, index, busy, done
    );
endinterface

// File: rtl/pattern_player.sv
// pattern_player: plays back the first N 3-bit patterns of a 16-entry bus as
// a one-hot LED sequence paced by an external tick strobe.
// Optional feature macro PATTERN_PLAYER_GAP_EN: when defined, GAP_TICKS blank
// ticks separate consecutive patterns so repeated values stay distinguishable.
// When undefined, patterns play back-to-back and GAP_TICKS is only
// range-checked.
module pattern_player #(
    parameter int unsigned HOLD_TICKS = 4,
    parameter int unsigned GAP_TICKS  = 1
) (
    input logic              clk,
    input logic              rst,
    pattern_player_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
`ifdef PATTERN_PLAYER_GAP_EN
        GAP,
`endif
        FIN
    } state_t;

    // Terminal counts: the counter runs 0..N-1, so it never needs to hold N.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);
`ifdef PATTERN_PLAYER_GAP_EN
    localparam logic [7:0] GAP_LAST  = 8'(GAP_TICKS - 1);
`endif

    // Reject out-of-range configurations at elaboration.
    if (HOLD_TICKS < 1 || HOLD_TICKS > 255 || GAP_TICKS < 1 || GAP_TICKS > 255) begin : g_bad_param
        $error("pattern_player: HOLD_TICKS and GAP_TICKS must be in 1..255");
    end

    state_t      state;
    logic [47:0] pat_q;    // pattern bus captured at start
    logic [3:0]  last_q;   // index of the final pattern (clamped length - 1)
    logic [7:0]  cnt;      // ticks elapsed in the current SHOW/GAP phase
    logic [3:0]  next_idx;

    assign next_idx = bus.index + 4'd1;

    // One-hot LED image of pattern i of a captured bus.
    function automatic logic [7:0] led_of(input logic [47:0] pats, input logic [3:0] i);
        logic [2:0] p;
        p = pats[{2'b00, i} * 6'd3 +: 3];
        return 8'b1 << p;
    endfunction

    // Clamp the requested length to 1..16 and return the final index.
    function automatic logic [3:0] last_of(input logic [4:0] len);
        if (len == 5'd0)
            return 4'd0;
        else if (len > 5'd16)
            return 4'd15;
        else
            return 4'(len - 5'd1);
    endfunction

    // Playback FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the captured pattern register is an ordinary flop bank,
            // so it is reset too; this keeps the block free of X after reset.
            state         <= IDLE;
            pat_q         <= '0;
            last_q        <= '0;
            cnt           <= '0;
            bus.led       <= '0;
            bus.led_valid <= 1'b0;
            bus.index     <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch
            // reads the pre-edge values of state, cnt and index.
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pat_q         <= bus.patterns;
                        last_q        <= last_of(bus.length);
                        cnt           <= '0;
                        bus.index     <= '0;
                        bus.led       <= led_of(bus.patterns, 4'd0);
                        bus.led_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                        state         <= SHOW;
                    end
                end

                SHOW: begin
                    if (bus.abort) begin
                        cnt           <= '0;
                        bus.led       <= '0;
                        bus.led_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end else if (bus.tick) begin
                        if (cnt == HOLD_LAST) begin
                            cnt <= '0;
                            if (bus.index == last_q) begin
                                bus.led       <= '0;
                                bus.led_valid <= 1'b0;
                                bus.busy      <= 1'b0;
                                bus.done      <= 1'b1;
                                state         <= FIN;
                            end else begin
`ifdef PATTERN_PLAYER_GAP_EN
                                bus.led       <= '0;
                                bus.led_valid <= 1'b0;
                                state         <= GAP;
`else
                                bus.index     <= next_idx;
                                bus.led       <= led_of(pat_q, next_idx);
`endif
                            end
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end

`ifdef PATTERN_PLAYER_GAP_EN
                GAP: begin
                    if (bus.abort) begin
                        cnt      <= '0;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end else if (bus.tick) begin
                        if (cnt == GAP_LAST) begin
                            cnt           <= '0;
                            bus.index     <= next_idx;
                            bus.led       <= led_of(pat_q, next_idx);
                            bus.led_valid <= 1'b1;
                            state         <= SHOW;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
`endif

                FIN: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player. A reference model tracks playback
// as a single count of ticks since start and derives the displayed pattern,
// blank gaps and completion from that count with plain arithmetic.
module tb_pattern_player;

    localparam int HOLD = 2;
    localparam int GAP  = 1;
`ifdef PATTERN_PLAYER_GAP_EN
    localparam int GAP_MODEL = GAP;
`else
    localparam int GAP_MODEL = 0;
`endif
    localparam int PERIOD = HOLD + GAP_MODEL;

    logic clk = 1'b0;
    logic rst = 1'b0;

    // Free-running system clock.
    always #5 clk = ~clk;

    pattern_player_if bus();

    pattern_player #(
        .HOLD_TICKS (HOLD),
        .GAP_TICKS  (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    typedef enum {M_IDLE, M_PLAY, M_FIN} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_pat[16];
    int      m_len   = 1;
    int      m_total = 1;
    int      m_k     = 0;
    int      m_idx   = 0;
    int      m_fins  = 0;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_idx   = 0;
        m_k     = 0;
    endtask

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        if (!rst) begin
            model_reset();
            return;
        end
        case (m_phase)
            M_IDLE: begin
                if (bus.start) begin
                    for (int j = 0; j < 16; j++) m_pat[j] = int'(bus.patterns[3*j +: 3]);
                    m_len   = (bus.length == 0) ? 1 : (bus.length > 16) ? 16 : int'(bus.length);
                    m_total = m_len * HOLD + (m_len - 1) * GAP_MODEL;
                    m_k     = 0;
                    m_idx   = 0;
                    m_phase = M_PLAY;
                end
            end
            M_PLAY: begin
                if (bus.abort) begin
                    m_phase = M_IDLE;
                end else if (bus.tick) begin
                    m_k++;
                    if (m_k == m_total) begin
                        m_phase = M_FIN;
                        m_fins++;
                    end else begin
                        m_idx = m_k / PERIOD;
                    end
                end
            end
            default: m_phase = M_IDLE;
        endcase
    endtask

    task automatic check_outputs();
        logic [7:0] e_led;
        logic       e_valid, e_busy, e_done;
        e_led = 8'h00; e_valid = 1'b0; e_busy = 1'b0; e_done = 1'b0;
        if (m_phase == M_PLAY) begin
            e_busy = 1'b1;
            if ((m_k % PERIOD) < HOLD) begin
                e_valid = 1'b1;
                e_led   = 8'(1 << m_pat[m_k / PERIOD]);
            end
        end else if (m_phase == M_FIN) begin
            e_done = 1'b1;
        end
        check("led",       48'(bus.led),       48'(e_led));
        check("led_valid", 48'(bus.led_valid), 48'(e_valid));
        check("busy",      48'(bus.busy),      48'(e_busy));
        check("done",      48'(bus.done),      48'(e_done));
        check("index",     48'(bus.index),     48'(m_idx));
    endtask

    // One clock: inputs already set, model follows the edge, outputs are
    // compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_inputs();
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
    endtask

    logic [7:0] led_seq[$];

    // Start one playback and run it to IDLE. tick_every=0 gives random ticks.
    task automatic run_one(input logic [47:0] pats, input logic [4:0] len,
                           input int tick_every, input bit tick_on_start,
                           input int abort_pct, input bit disturb,
                           output int dones, output int ticks);
        int         cycles;
        int         fins_before;
        logic [7:0] last_led;
        led_seq.delete();
        fins_before = m_fins;
        dones    = 0;
        ticks    = 0;
        cycles   = 0;
        last_led = 8'h00;
        bus.patterns = pats;
        bus.length   = len;
        bus.start    = 1'b1;
        bus.tick     = tick_on_start;
        bus.abort    = 1'b0;
        cycle();
        if (bus.led != last_led) begin
            led_seq.push_back(bus.led);
            last_led = bus.led;
        end
        bus.start = 1'b0;
        while (m_phase != M_IDLE && cycles < 4000) begin
            if (tick_every == 0)
                bus.tick = ($urandom_range(0, 2) == 0);
            else
                bus.tick = ((cycles % tick_every) == tick_every - 1);
            bus.abort = (abort_pct > 0) && ($urandom_range(0, 99) < abort_pct);
            if (disturb) begin
                bus.patterns = 48'({$urandom(), $urandom()});
                bus.length   = 5'($urandom_range(0, 31));
                bus.start    = ($urandom_range(0, 5) == 0);
            end
            if (bus.tick && !bus.abort && m_phase == M_PLAY) ticks++;
            cycle();
            if (bus.done) dones++;
            if (bus.led != last_led) begin
                led_seq.push_back(bus.led);
                last_led = bus.led;
            end
            cycles++;
        end
        check("run_timeout", 48'(cycles < 4000), 48'(1));
        check("done_count", 48'(dones), 48'(m_fins - fins_before));
        clear_inputs();
    endtask

    initial begin
        int dones, ticks, total;
        logic [7:0] exp_seq[$];

        clear_inputs();
        bus.patterns = '0;
        bus.length   = '0;

        // Reset state.
        #1;
        check("rst_led",   48'(bus.led),       48'(0));
        check("rst_valid", 48'(bus.led_valid), 48'(0));
        check("rst_busy",  48'(bus.busy),      48'(0));
        check("rst_done",  48'(bus.done),      48'(0));
        check("rst_index", 48'(bus.index),     48'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        cycle();

        // Basic sequence: patterns 5,0,7, tick every 4 cycles.
        run_one(48'h1C5, 5'd3, 4, 1'b0, 0, 1'b0, dones, ticks);
`ifdef PATTERN_PLAYER_GAP_EN
        exp_seq = '{8'h20, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00};
        check("basic_ticks", 48'(ticks), 48'(8));
`else
        exp_seq = '{8'h20, 8'h01, 8'h80, 8'h00};
        check("basic_ticks", 48'(ticks), 48'(6));
`endif
        check("basic_done", 48'(dones), 48'(1));
        check("basic_seq_len", 48'(led_seq.size()), 48'(exp_seq.size()));
        for (int i = 0; i < exp_seq.size() && i < led_seq.size(); i++)
            check("basic_seq", 48'(led_seq[i]), 48'(exp_seq[i]));
        check("basic_final_idx", 48'(bus.index), 48'(2));

        // Repeated values: pattern 3 twice.
        run_one(48'h01B, 5'd2, 2, 1'b0, 0, 1'b0, dones, ticks);
`ifdef PATTERN_PLAYER_GAP_EN
        check("repeat_seq_len", 48'(led_seq.size()), 48'(4));
`else
        check("repeat_seq_len", 48'(led_seq.size()), 48'(2));
        check("repeat_lit", 48'(led_seq[0]), 48'(8'h08));
`endif
        check("repeat_done", 48'(dones), 48'(1));

        // Length clamping.
        run_one(48'hFFF_FFFF_FFF3, 5'd0, 1, 1'b0, 0, 1'b0, dones, ticks);
        check("len0_ticks", 48'(ticks), 48'(HOLD));
        check("len0_idx", 48'(bus.index), 48'(0));
        run_one(48'h0123_4567_89AB, 5'd20, 1, 1'b0, 0, 1'b0, dones, ticks);
        check("len20_ticks", 48'(ticks), 48'(16 * HOLD + 15 * GAP_MODEL));
        check("len20_idx", 48'(bus.index), 48'(15));

        // Abort coinciding with the final terminal tick.
        total = 2 * HOLD + GAP_MODEL;
        dones = 0;
        bus.patterns = 48'h02A;
        bus.length   = 5'd2;
        bus.start    = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int t = 1; t <= total; t++) begin
            bus.tick  = 1'b1;
            bus.abort = (t == total);
            cycle();
            if (bus.done) dones++;
        end
        check("abort_busy", 48'(bus.busy), 48'(0));
        clear_inputs();
        repeat (3) begin
            cycle();
            if (bus.done) dones++;
        end
        check("abort_no_done", 48'(dones), 48'(0));

        // Start during playback is ignored; inputs change mid-playback.
        run_one(48'h0FED_CBA9_8765, 5'd6, 1, 1'b1, 0, 1'b1, dones, ticks);
        check("isolate_ticks", 48'(ticks), 48'(6 * HOLD + 5 * GAP_MODEL));

        // Asynchronous reset mid-playback at index 2.
        bus.patterns = 48'h0000_0000_0FAC;
        bus.length   = 5'd16;
        bus.start    = 1'b1;
        cycle();
        bus.start = 1'b0;
        for (int c = 0; c < 200 && !(m_phase == M_PLAY && m_idx == 2); c++) begin
            bus.tick = 1'b1;
            cycle();
        end
        bus.tick = 1'b0;
        check("rst_reach_idx", 48'(bus.index), 48'(2));
        #2 rst = 1'b0;
        model_reset();
        #1;
        check("arst_led",   48'(bus.led),       48'(0));
        check("arst_valid", 48'(bus.led_valid), 48'(0));
        check("arst_busy",  48'(bus.busy),      48'(0));
        check("arst_done",  48'(bus.done),      48'(0));
        check("arst_index", 48'(bus.index),     48'(0));
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b1;
        check_outputs();
        run_one(48'h0000_0000_0FAC, 5'd4, 2, 1'b0, 0, 1'b0, dones, ticks);
        check("post_rst_done", 48'(dones), 48'(1));

        // Randomized playbacks.
        for (int n = 0; n < 25; n++) begin
            run_one(48'({$urandom(), $urandom()}), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 2) == 0) ? 2 : 0, 1'($urandom_range(0, 1)),
                    dones, ticks);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
